// File: rtl/encoder_emulator.sv
// Quadrature encoder signal generator: emits A/B/I waveforms, a wrapped position
// count and a per-edge strobe, driven either by a rate timer or by single-step requests.
module encoder_emulator #(
  parameter int K_PERIOD_W = 16,
  parameter int K_CPR_W    = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_direction,
  input  logic                  i_polarity,
  input  logic [K_PERIOD_W-1:0] i_period,
  input  logic [K_CPR_W-1:0]    i_cpr,
  input  logic                  i_index_en,
  input  logic                  i_step_valid,
  output logic                  o_step_ready,
  output logic                  o_a,
  output logic                  o_b,
  output logic                  o_i,
  output logic [K_CPR_W-1:0]    o_position,
  output logic                  o_step,
  output logic                  o_dir
);

  logic [1:0]            ph, ph_d;
  logic [K_PERIOD_W-1:0] tm, tm_d;
  logic [K_PERIOD_W:0]   tm_plus1, tm_d_plus1, period_x;
  logic [K_CPR_W-1:0]    cpr_eff, position_d;
  logic                  enable_q, mode_change;
  logic                  edge_fire, edge_dir, ready_d;
  logic                  a_int, b_int;

  // NOTE: every signal driven here gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    cpr_eff     = (i_cpr < K_CPR_W'(4)) ? K_CPR_W'(4) : i_cpr;
    period_x    = {1'b0, i_period};
    tm_plus1    = {1'b0, tm} + (K_PERIOD_W+1)'(1);
    mode_change = i_enable ^ enable_q;
    edge_fire   = 1'b0;
    edge_dir    = i_direction;
    tm_d        = tm;

    // Timer compares as tm+1 >= period so a zero period never underflows.
    if (mode_change) begin
      tm_d = '0;
    end else if (i_enable) begin
      if (i_period == '0) begin
        tm_d = '0;
      end else if (tm_plus1 >= period_x) begin
        edge_fire = 1'b1;
        tm_d      = '0;
      end else begin
        tm_d = tm + K_PERIOD_W'(1);
      end
    end else begin
      if (i_step_valid && o_step_ready) begin
        edge_fire = 1'b1;
        tm_d      = '0;
      end else if (!(&tm)) begin
        tm_d = tm + K_PERIOD_W'(1);
      end
    end

    ph_d       = ph;
    position_d = o_position;
    if (edge_fire) begin
      if (!edge_dir) begin
        ph_d       = ph + 2'd1;
        position_d = (o_position >= cpr_eff - K_CPR_W'(1)) ? '0 : o_position + K_CPR_W'(1);
      end else begin
        ph_d       = ph - 2'd1;
        position_d = (o_position == '0) ? cpr_eff - K_CPR_W'(1) : o_position - K_CPR_W'(1);
      end
    end

    // Gray mapping ph0..3 -> {A,B} = 00,10,11,01.
    a_int = ph_d[1] ^ ph_d[0];
    b_int = ph_d[1];

    tm_d_plus1 = {1'b0, tm_d} + (K_PERIOD_W+1)'(1);
    ready_d    = !i_enable && ((tm_d_plus1 >= period_x) || (i_period == '0));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ph           <= '0;
      tm           <= '0;
      enable_q     <= 1'b0;
      o_position   <= '0;
      o_a          <= 1'b0;
      o_b          <= 1'b0;
      o_i          <= 1'b0;
      o_step       <= 1'b0;
      o_dir        <= 1'b0;
      o_step_ready <= 1'b0;
    end else begin
      ph           <= ph_d;
      tm           <= tm_d;
      enable_q     <= i_enable;
      o_position   <= position_d;
      o_a          <= i_polarity ? b_int : a_int;
      o_b          <= i_polarity ? a_int : b_int;
      o_i          <= i_index_en && (position_d == '0);
      o_step       <= edge_fire;
      o_step_ready <= ready_d;
      if (edge_fire) begin
        o_dir <= edge_dir;
      end
    end
  end

endmodule

// File: tb/tb_encoder_emulator.sv
// Directed bench for encoder_emulator: table-driven continuous and manual vectors
// plus hand-written sequences for reset, cpr and period corner cases.
module tb_encoder_emulator;

  localparam int PW = 16;
  localparam int CW = 12;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_enable;
  logic          i_direction;
  logic          i_polarity;
  logic [PW-1:0] i_period;
  logic [CW-1:0] i_cpr;
  logic          i_index_en;
  logic          i_step_valid;
  logic          o_step_ready;
  logic          o_a;
  logic          o_b;
  logic          o_i;
  logic [CW-1:0] o_position;
  logic          o_step;
  logic          o_dir;

  encoder_emulator #(.K_PERIOD_W(PW), .K_CPR_W(CW)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_enable     (i_enable),
    .i_direction  (i_direction),
    .i_polarity   (i_polarity),
    .i_period     (i_period),
    .i_cpr        (i_cpr),
    .i_index_en   (i_index_en),
    .i_step_valid (i_step_valid),
    .o_step_ready (o_step_ready),
    .o_a          (o_a),
    .o_b          (o_b),
    .o_i          (o_i),
    .o_position   (o_position),
    .o_step       (o_step),
    .o_dir        (o_dir)
  );

  always #5 i_clk = ~i_clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_reset_state();
    check("rst_a",     32'(o_a), 0);
    check("rst_b",     32'(o_b), 0);
    check("rst_i",     32'(o_i), 0);
    check("rst_pos",   32'(o_position), 0);
    check("rst_step",  32'(o_step), 0);
    check("rst_dir",   32'(o_dir), 0);
    check("rst_ready", 32'(o_step_ready), 0);
  endtask

  // Continuous-mode vector: inputs for the period, expected outputs at its edge.
  typedef struct {
    logic          dir;
    logic          pol;
    logic [CW-1:0] pos;
    logic          a;
    logic          b;
    logic          idx;
    logic          dir_o;
  } cvec_t;

  // Manual-mode vector: inputs for one cycle, expected outputs after that clock.
  typedef struct {
    logic          valid;
    logic          dir;
    logic          step;
    logic          ready;
    logic [CW-1:0] pos;
    logic          dir_o;
  } mvec_t;

  function automatic cvec_t mk_c(input int dir, input int pol, input int pos,
                                 input int a, input int b, input int idx, input int dir_o);
    cvec_t c;
    c.dir = dir[0]; c.pol = pol[0]; c.pos = CW'(pos);
    c.a = a[0]; c.b = b[0]; c.idx = idx[0]; c.dir_o = dir_o[0];
    return c;
  endfunction

  function automatic mvec_t mk_m(input int valid, input int dir, input int step,
                                 input int ready, input int pos, input int dir_o);
    mvec_t m;
    m.valid = valid[0]; m.dir = dir[0]; m.step = step[0];
    m.ready = ready[0]; m.pos = CW'(pos); m.dir_o = dir_o[0];
    return m;
  endfunction

  cvec_t cont_tbl[16];
  mvec_t man_tbl[13];

  initial begin
    logic [CW-1:0] prev_pos;
    logic          step_seen;

    // forward, polarity 0: positions 1..7 then wrap to 0
    cont_tbl[0]  = mk_c(0, 0, 1, 1, 0, 0, 0);
    cont_tbl[1]  = mk_c(0, 0, 2, 1, 1, 0, 0);
    cont_tbl[2]  = mk_c(0, 0, 3, 0, 1, 0, 0);
    cont_tbl[3]  = mk_c(0, 0, 4, 0, 0, 0, 0);
    cont_tbl[4]  = mk_c(0, 0, 5, 1, 0, 0, 0);
    cont_tbl[5]  = mk_c(0, 0, 6, 1, 1, 0, 0);
    cont_tbl[6]  = mk_c(0, 0, 7, 0, 1, 0, 0);
    cont_tbl[7]  = mk_c(0, 0, 0, 0, 0, 1, 0);
    // reverse from 0
    cont_tbl[8]  = mk_c(1, 0, 7, 0, 1, 0, 1);
    cont_tbl[9]  = mk_c(1, 0, 6, 1, 1, 0, 1);
    cont_tbl[10] = mk_c(1, 0, 5, 1, 0, 0, 1);
    cont_tbl[11] = mk_c(1, 0, 4, 0, 0, 0, 1);
    // forward with pins swapped
    cont_tbl[12] = mk_c(0, 1, 5, 0, 1, 0, 0);
    cont_tbl[13] = mk_c(0, 1, 6, 1, 1, 0, 0);
    cont_tbl[14] = mk_c(0, 1, 7, 1, 0, 0, 0);
    cont_tbl[15] = mk_c(0, 1, 0, 0, 0, 1, 0);

    // manual P=3 starting at position 2, ready already 1
    man_tbl[0]  = mk_m(1, 0, 1, 0, 3, 0);
    man_tbl[1]  = mk_m(1, 0, 0, 0, 3, 0);
    man_tbl[2]  = mk_m(1, 1, 0, 1, 3, 0);
    man_tbl[3]  = mk_m(1, 1, 1, 0, 2, 1);
    man_tbl[4]  = mk_m(1, 1, 0, 0, 2, 1);
    man_tbl[5]  = mk_m(1, 1, 0, 1, 2, 1);
    man_tbl[6]  = mk_m(1, 1, 1, 0, 1, 1);
    man_tbl[7]  = mk_m(1, 0, 0, 0, 1, 1);
    man_tbl[8]  = mk_m(1, 0, 0, 1, 1, 1);
    man_tbl[9]  = mk_m(1, 0, 1, 0, 2, 0);
    man_tbl[10] = mk_m(1, 0, 0, 0, 2, 0);  // request while not ready: dropped
    man_tbl[11] = mk_m(0, 0, 0, 1, 2, 0);
    man_tbl[12] = mk_m(0, 0, 0, 1, 2, 0);  // nothing was queued

    i_rst = 1'b1; i_enable = 1'b1; i_direction = 1'b0; i_polarity = 1'b0;
    i_period = PW'(4); i_cpr = CW'(8); i_index_en = 1'b1; i_step_valid = 1'b0;

    tick();
    check_reset_state();
    i_rst = 1'b0;
    tick();
    check("idx_after_reset", 32'(o_i), 1);
    check("pos_after_reset", 32'(o_position), 0);
    check("no_step_on_enable", 32'(o_step), 0);

    // Continuous P=4: three quiet cycles then an edge, per table entry.
    prev_pos = '0;
    for (int v = 0; v < 16; v++) begin
      i_direction = cont_tbl[v].dir;
      i_polarity  = cont_tbl[v].pol;
      for (int c = 0; c < 3; c++) begin
        tick();
        check("cont_idle_step", 32'(o_step), 0);
        check("cont_idle_pos", 32'(o_position), 32'(prev_pos));
        check("cont_idle_idx", 32'(o_i), (prev_pos == '0) ? 1 : 0);
        check("cont_ready_low", 32'(o_step_ready), 0);
      end
      tick();
      check("cont_edge_step", 32'(o_step), 1);
      check("cont_edge_pos", 32'(o_position), 32'(cont_tbl[v].pos));
      check("cont_edge_a", 32'(o_a), 32'(cont_tbl[v].a));
      check("cont_edge_b", 32'(o_b), 32'(cont_tbl[v].b));
      check("cont_edge_idx", 32'(o_i), 32'(cont_tbl[v].idx));
      check("cont_edge_dir", 32'(o_dir), 32'(cont_tbl[v].dir_o));
      prev_pos = cont_tbl[v].pos;
    end

    // Mid-run reset at position 5.
    i_polarity = 1'b0; i_direction = 1'b0;
    repeat (20) tick();
    check("pre_reset_pos", 32'(o_position), 5);
    i_rst = 1'b1;
    tick();
    check_reset_state();
    i_rst = 1'b0;
    tick();
    check("restart_idx", 32'(o_i), 1);
    check("restart_pos", 32'(o_position), 0);
    repeat (3) tick();
    check("restart_quiet", 32'(o_step), 0);
    tick();
    check("restart_step", 32'(o_step), 1);
    check("restart_pos1", 32'(o_position), 1);
    check("restart_a", 32'(o_a), 1);
    check("restart_b", 32'(o_b), 0);

    // cpr=2 acts as 4; P=1 gives an edge every cycle.
    i_period = PW'(1); i_cpr = CW'(2);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("cpr2_step", 32'(o_step), 1);
      check("cpr2_pos", 32'(o_position), (k == 2) ? 0 : k + 2);
    end
    check("cpr2_idx", 32'(o_i), 1);
    check("cpr2_a", 32'(o_a), 0);

    // cpr 8 -> 4 while at position 6: next forward edge wraps to 0.
    i_cpr = CW'(8);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("cpr8_pos", 32'(o_position), k);
    end
    i_cpr = CW'(4);
    tick();
    check("cpr_shrink_pos", 32'(o_position), 0);
    check("cpr_shrink_a", 32'(o_a), 0);
    check("cpr_shrink_b", 32'(o_b), 1);

    // Period 100 -> 2 at tm=50: edge on the next clock.
    i_period = PW'(100);
    step_seen = 1'b0;
    repeat (50) begin
      tick();
      if (o_step) step_seen = 1'b1;
    end
    check("p100_no_edge", 32'(step_seen), 0);
    i_period = PW'(2);
    tick();
    check("p_change_step", 32'(o_step), 1);
    check("p_change_pos", 32'(o_position), 1);
    tick();
    check("p2_quiet", 32'(o_step), 0);
    tick();
    check("p2_step", 32'(o_step), 1);
    check("p2_pos", 32'(o_position), 2);

    // Manual mode P=3.
    i_enable = 1'b0; i_period = PW'(3); i_cpr = CW'(8);
    repeat (4) tick();
    check("man_ready", 32'(o_step_ready), 1);
    check("man_hold_step", 32'(o_step), 0);
    check("man_hold_pos", 32'(o_position), 2);
    for (int v = 0; v < 13; v++) begin
      i_step_valid = man_tbl[v].valid;
      i_direction  = man_tbl[v].dir;
      tick();
      check("man_step", 32'(o_step), 32'(man_tbl[v].step));
      check("man_ready", 32'(o_step_ready), 32'(man_tbl[v].ready));
      check("man_pos", 32'(o_position), 32'(man_tbl[v].pos));
      check("man_dir", 32'(o_dir), 32'(man_tbl[v].dir_o));
    end
    i_step_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/encoder_emulator.md
# encoder_emulator

Quadrature encoder signal generator: produces A/B/I waveforms, a matching position count and a step strobe from a rate or single-step command. It is the transmit-side counterpart of the encoder reader in the motor control path. It drives the reader inputs in closed-loop benches and HIL setups, and emulates a motor encoder when no motor is fitted. Edge spacing, direction, counts-per-revolution and index placement are programmable at runtime.

## Interface

Parameters:
- K_PERIOD_W, 16: width of the edge-period setting, in clock cycles.
- K_CPR_W, 12: width of the counts-per-revolution setting and of the position output.

Ports:
- i_clk, in, 1: master clock.
- i_rst, in, 1: reset, synchronous, active-high.
- i_enable, in, 1: 1 selects continuous mode; 0 selects manual single-step mode.
- i_direction, in, 1: 0 = forward (A leads B, position increments); 1 = reverse.
- i_polarity, in, 1: 1 swaps the A and B output pins. Same meaning as the encoder reader polarity parameter.
- i_period, in, K_PERIOD_W: clock cycles between consecutive quadrature edges. In continuous mode, 0 means stopped. In manual mode it is the minimum edge spacing.
- i_cpr, in, K_CPR_W: quadrature edges per revolution. Values below 4 are treated as 4.
- i_index_en, in, 1: enables the index output.
- i_step_valid, in, 1: manual step request. Accepted when o_step_ready is 1.
- o_step_ready, out, 1: manual step can be accepted.
- o_a, out, 1: encoder A.
- o_b, out, 1: encoder B.
- o_i, out, 1: encoder index.
- o_position, out, K_CPR_W: current position, 0..cpr-1.
- o_step, out, 1: one-cycle pulse coincident with every A/B edge.
- o_dir, out, 1: direction of the last generated edge.

## Operation

- Internal 2-bit phase ph. Unswapped {A,B} mapping: ph0 = 00, ph1 = 10, ph2 = 11, ph3 = 01.
- Forward edge: ph+1 mod 4, position+1. Reverse edge: ph-1 mod 4, position-1.
- Position wrap: forward from cpr-1 (or any value ≥ cpr after a cpr change) goes to 0. Reverse from 0 goes to cpr-1.
- i_polarity=1 swaps the output pins only: o_a = B_int, o_b = A_int. ph and position are unaffected.
- o_i = i_index_en & (position == 0), registered from the updated position. The index is high for exactly one quadrature state per revolution.
- Timer: a K_PERIOD_W counter tm. It counts 0 upward and clears on every generated edge and whenever the mode changes.
- Continuous mode (i_enable=1, i_period≠0):
  - An edge is generated when tm ≥ i_period-1, then tm clears.
  - Direction is sampled at the edge.
- Continuous mode with i_period=0: no edges; tm held at 0; outputs hold.
- Manual mode (i_enable=0):
  - o_step_ready = (tm ≥ i_period-1) | (i_period == 0). tm saturates rather than wrapping.
  - i_step_valid & o_step_ready generates one edge, direction = i_direction, and clears tm.
  - i_step_valid while o_step_ready=0 is ignored; it is not queued.
  - o_step_ready=0 in continuous mode.
- Period change mid-count: compare against the new value. If the new i_period-1 ≤ tm, the edge fires on the next clock.
- Disable mid-run: tm clears; ph, position and outputs hold. Re-enabling restarts a full period.
- Mid-operation i_rst: all state returns to reset values on that clock edge.

## Timing

- All outputs registered.
- Reset values: o_a=0, o_b=0, o_i=0, o_position=0, o_step=0, o_dir=0, o_step_ready=0. Internally ph=0 and tm=0.
- o_i follows i_index_en one cycle after reset release, because position is 0.
- o_a, o_b, o_position, o_dir, o_step and o_i update on the same clock edge for a given step. The index changes in the same cycle as its A/B edge.
- Continuous, period P: the first edge occurs P cycles after i_enable rises, then every P cycles. P=1 gives an edge every cycle.
- Manual: request accepted at clock n gives outputs updated at clock n+1. o_step_ready drops at n+1 and returns P-1 cycles later when P>1. It stays 1 when P ≤ 1.
- i_polarity and i_index_en act combinationally on the next register update; they do not generate o_step.

## Test plan

- Reset, i_enable=1, P=4, cpr=8, forward, index on:
  - {A,B} sequence 00,10,11,01,00 with one edge every 4 cycles.
  - Position runs 0..7 then 0.
  - o_i high only while position=0.
  - o_step pulses 1 cycle per edge.
- Reverse from position 0, cpr=8: position goes 7, 6, …; {A,B} sequence 00,01,11,10; o_dir=1.
- Polarity: i_polarity=1 with the same stimulus gives o_a/o_b swapped relative to the first test; position is unchanged.
- Manual mode, P=3:
  - Hold i_step_valid high for 10 cycles: edges on every third cycle.
  - o_step_ready pattern 1,0,0,1,….
  - A request while not ready is dropped.
- Boundaries:
  - cpr=2 behaves as 4.
  - Changing cpr from 8 to 4 with position=6 wraps to 0 on the next forward edge.
  - Changing P from 100 to 2 at tm=50 fires an edge on the next clock.
- i_rst asserted mid-run at position 5: all outputs take reset values on the next clock and continuous stepping restarts from position 0.
